leta_poll_ctrl: RTL and testbench

//  Polling sequencer for the LETA trackball counter chip. Cycles LETA address 0..3, samples DB after
//  a settle delay, turns raw 8-bit counter values into signed deltas, and accumulates them into a

---
 rtl/leta_pkg.sv | 32 +++
 rtl/leta_axis_accum.sv | 71 +++++++
 rtl/leta_poll_ctrl.sv | 167 ++++++++++++++++
 tb/tb_leta_poll_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/leta_pkg.sv
// Shared types and constants for the LETA trackball polling sequencer.
package leta_pkg;

    // Poll sequencer states
    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StSample,
        StEval,
        StEmit,
        StGap
    } leta_state_e;

    // LETA counter addresses
    localparam logic [1:0] AD_X = 2'd0;
    localparam logic [1:0] AD_Y = 2'd1;
    localparam logic [1:0] AD_R = 2'd2;
    localparam logic [1:0] AD_G = 2'd3;

    // Output widths
    localparam int unsigned XW = 11;
    localparam int unsigned YW = 10;
    localparam int unsigned CW = 8;

    // LETA data width and accumulation arithmetic width
    localparam int unsigned DW = 8;
    localparam int unsigned AW = 13;

    // Poll-phase timer width
    localparam int unsigned TW = 16;

endpackage

// File: rtl/leta_axis_accum.sv
// One LETA channel: captures the raw counter, derives a signed delta against the previous
// frame's baseline, and accumulates it either clamped to [0, MAX] or wrapping mod 2^W.
module leta_axis_accum
    import leta_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned MAX   = 255,
    parameter int unsigned INIT  = 0,
    parameter bit          CLAMP = 1'b0,
    parameter int unsigned SHIFT = 0
) (
    input  logic          CK,
    input  logic          reset_n,
    input  logic          cap,
    input  logic [DW-1:0] db,
    input  logic          eval,
    input  logic          primed,
    output logic [W-1:0]  value,
    output logic          changed
);

    localparam logic signed [AW-1:0] MaxS = AW'(MAX);

    logic [DW-1:0]        cnt_q;
    logic [DW-1:0]        base_q;
    logic [W-1:0]         value_q;
    logic [W-1:0]         value_d;
    logic [DW-1:0]        delta;
    logic signed [AW-1:0] d_ext;
    logic signed [AW-1:0] d_shift;
    logic signed [AW-1:0] sum;

    // Delta, gain and clamp/wrap of the next accumulated value
    always_comb begin
        delta   = cnt_q - base_q;  // mod-256 difference, read as two's complement
        d_ext   = {{(AW - DW){delta[DW-1]}}, delta};
        d_shift = d_ext <<< SHIFT;
        sum     = $signed({{(AW - W){1'b0}}, value_q}) + d_shift;
        value_d = sum[W-1:0];
        if (CLAMP) begin
            if (sum[AW-1]) begin
                value_d = '0;
            end else if (sum > MaxS) begin
                value_d = W'(MAX);
            end
        end
        changed = primed && (value_d != value_q);
    end

    // Raw capture, baseline update every evaluation, accumulate once primed
    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            base_q  <= '0;
            value_q <= W'(INIT);
        end else begin
            if (cap) begin
                cnt_q <= db;
            end
            if (eval) begin
                base_q <= cnt_q;
                if (primed) begin
                    value_q <= value_d;
                end
            end
        end
    end

    assign value = value_q;

endmodule

// File: rtl/leta_poll_ctrl.sv
// LETA polling sequencer: walks addresses 0..3, samples each counter after a settle delay,
// folds the deltas into cursor X/Y and colour R/G, and offers one update per changed frame.
module leta_poll_ctrl
    import leta_pkg::*;
#(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned GAP    = 16,
    parameter int unsigned X_MAX  = 639,
    parameter int unsigned Y_MAX  = 479,
    parameter int unsigned X_INIT = 320,
    parameter int unsigned Y_INIT = 240,
    parameter int unsigned SHIFT  = 0
) (
    input  logic          CK,
    input  logic          reset_n,
    input  logic          en,
    output logic [1:0]    leta_ad,
    output logic          leta_cs_n,
    input  logic [DW-1:0] leta_db,
    output logic          upd_valid,
    input  logic          upd_ready,
    output logic [XW-1:0] upd_x,
    output logic [YW-1:0] upd_y,
    output logic [XW-1:0] upd_px,
    output logic [YW-1:0] upd_py,
    output logic [CW-1:0] upd_r,
    output logic [CW-1:0] upd_g,
    output logic          busy
);

    leta_state_e   state_q, state_d;
    logic [1:0]    idx_q, idx_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          primed_q, primed_d;
    logic [XW-1:0] px_q, px_d;
    logic [YW-1:0] py_q, py_d;

    logic          sample;
    logic          eval;
    logic          ch_x, ch_y, ch_r, ch_g;
    logic          gap_done;

    assign sample   = (state_q == StSample);
    assign eval     = (state_q == StEval);
    // GAP state lasts at least one cycle even when GAP is 0
    assign gap_done = ({{(32 - TW){1'b0}}, timer_q} + 32'd1) >= GAP;

    leta_axis_accum #(
        .W(XW), .MAX(X_MAX), .INIT(X_INIT), .CLAMP(1'b1), .SHIFT(SHIFT)
    ) u_acc_x (
        .CK(CK), .reset_n(reset_n), .cap(sample && (idx_q == AD_X)), .db(leta_db),
        .eval(eval), .primed(primed_q), .value(upd_x), .changed(ch_x)
    );

    leta_axis_accum #(
        .W(YW), .MAX(Y_MAX), .INIT(Y_INIT), .CLAMP(1'b1), .SHIFT(SHIFT)
    ) u_acc_y (
        .CK(CK), .reset_n(reset_n), .cap(sample && (idx_q == AD_Y)), .db(leta_db),
        .eval(eval), .primed(primed_q), .value(upd_y), .changed(ch_y)
    );

    leta_axis_accum #(
        .W(CW), .MAX(255), .INIT(0), .CLAMP(1'b0), .SHIFT(0)
    ) u_acc_r (
        .CK(CK), .reset_n(reset_n), .cap(sample && (idx_q == AD_R)), .db(leta_db),
        .eval(eval), .primed(primed_q), .value(upd_r), .changed(ch_r)
    );

    leta_axis_accum #(
        .W(CW), .MAX(255), .INIT(0), .CLAMP(1'b0), .SHIFT(0)
    ) u_acc_g (
        .CK(CK), .reset_n(reset_n), .cap(sample && (idx_q == AD_G)), .db(leta_db),
        .eval(eval), .primed(primed_q), .value(upd_g), .changed(ch_g)
    );

    // Next-state logic for the poll sequence and the update handshake
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        primed_d = primed_q;
        px_d     = px_q;
        py_d     = py_q;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StSetup;
                    idx_d   = AD_X;
                    timer_d = '0;
                end
            end
            StSetup: begin
                if (timer_q == TW'(SETTLE - 1)) begin
                    timer_d = '0;
                    state_d = StSample;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StSample: begin
                if (idx_q == AD_G) begin
                    state_d = StEval;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StSetup;
                end
            end
            StEval: begin
                timer_d = '0;
                if (!primed_q) begin
                    primed_d = 1'b1;
                    state_d  = StGap;
                end else if (ch_x || ch_y || ch_r || ch_g) begin
                    state_d = StEmit;
                end else begin
                    state_d = StGap;
                end
            end
            StEmit: begin
                if (upd_ready) begin
                    px_d    = upd_x;
                    py_d    = upd_y;
                    timer_d = '0;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_done) begin
                    timer_d = '0;
                    idx_d   = AD_X;
                    state_d = en ? StSetup : StIdle;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and bookkeeping registers
    always_ff @(posedge CK or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            idx_q    <= AD_X;
            timer_q  <= '0;
            primed_q <= 1'b0;
            px_q     <= XW'(X_INIT);
            py_q     <= YW'(Y_INIT);
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            primed_q <= primed_d;
            px_q     <= px_d;
            py_q     <= py_d;
        end
    end

    // Chip select is held only while addressing and sampling; address stays frozen otherwise
    assign leta_ad   = idx_q;
    assign leta_cs_n = !((state_q == StSetup) || (state_q == StSample));
    assign upd_valid = (state_q == StEmit);
    assign busy      = (state_q != StIdle);
    assign upd_px    = px_q;
    assign upd_py    = py_q;

endmodule

// File: tb/tb_leta_poll_ctrl.sv
// Directed bench for leta_poll_ctrl with a combinational LETA counter model.
module tb_leta_poll_ctrl;

    logic        CK = 1'b0;
    logic        reset_n;
    logic        en;
    logic        upd_ready;
    logic [1:0]  leta_ad;
    logic        leta_cs_n;
    logic [7:0]  leta_db;
    logic        upd_valid;
    logic [10:0] upd_x, upd_px;
    logic [9:0]  upd_y, upd_py;
    logic [7:0]  upd_r, upd_g;
    logic        busy;

    logic [7:0]  db_mem [4];
    int          n_tests = 0;
    int          n_fail  = 0;

    assign leta_db = db_mem[leta_ad];

    always #5 CK = ~CK;

    leta_poll_ctrl dut (
        .CK(CK), .reset_n(reset_n), .en(en), .leta_ad(leta_ad), .leta_cs_n(leta_cs_n),
        .leta_db(leta_db), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_x(upd_x),
        .upd_y(upd_y), .upd_px(upd_px), .upd_py(upd_py), .upd_r(upd_r), .upd_g(upd_g),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_cnt(input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] r, input logic [7:0] g);
        db_mem[0] = x;
        db_mem[1] = y;
        db_mem[2] = r;
        db_mem[3] = g;
    endtask

    // Runs to the cycle after EVAL of the next frame and reports whether an update is offered
    task automatic wait_frame(output logic got);
        int n;
        n = 0;
        while (leta_cs_n !== 1'b0 && n < 200) begin
            @(negedge CK);
            n++;
        end
        check("frame_start", 32'(n < 200), 1);
        n = 0;
        while (leta_cs_n !== 1'b1 && n < 50) begin
            @(negedge CK);
            n++;
        end
        check("frame_end", 32'(n < 50), 1);
        @(negedge CK);
        got = upd_valid;
    endtask

    task automatic ack();
        upd_ready = 1'b1;
        @(negedge CK);
        upd_ready = 1'b0;
        check("ack_drop", upd_valid, 0);
    endtask

    task automatic expect_upd(input string tag, input int x, input int y, input int px,
                              input int py, input int r, input int g);
        logic got;
        wait_frame(got);
        check({tag, "_valid"}, got, 1);
        check({tag, "_x"}, upd_x, x);
        check({tag, "_y"}, upd_y, y);
        check({tag, "_px"}, upd_px, px);
        check({tag, "_py"}, upd_py, py);
        check({tag, "_r"}, upd_r, r);
        check({tag, "_g"}, upd_g, g);
    endtask

    initial begin
        logic got;
        logic stable;
        logic saw3;
        int   n;

        // Reset state
        reset_n   = 1'b0;
        en        = 1'b0;
        upd_ready = 1'b0;
        set_cnt(8'h10, 8'h10, 8'h10, 8'h10);
        repeat (3) @(negedge CK);
        check("rst_valid", upd_valid, 0);
        check("rst_cs_n", leta_cs_n, 1);
        check("rst_ad", leta_ad, 0);
        check("rst_busy", busy, 0);
        check("rst_x", upd_x, 320);
        check("rst_y", upd_y, 240);
        check("rst_px", upd_px, 320);
        check("rst_py", upd_py, 240);
        check("rst_r", upd_r, 0);
        check("rst_g", upd_g, 0);

        // Priming frame: address walk with SETTLE=2 cycles per address, no update
        reset_n = 1'b1;
        @(negedge CK);
        en = 1'b1;
        @(negedge CK);
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < 2; s++) begin
                check("t1_setup_cs_ad", {leta_cs_n, leta_ad}, {1'b0, 2'(i)});
                check("t1_setup_valid", upd_valid, 0);
                @(negedge CK);
            end
            check("t1_sample_cs_ad", {leta_cs_n, leta_ad}, {1'b0, 2'(i)});
            @(negedge CK);
        end
        check("t1_eval_cs_n", leta_cs_n, 1);
        @(negedge CK);
        check("t1_gap_valid", upd_valid, 0);
        check("t1_gap_busy", busy, 1);

        // First real motion
        set_cnt(8'h15, 8'h0E, 8'h10, 8'h10);
        expect_upd("t2", 325, 238, 320, 240, 0, 0);
        ack();
        check("t2_px_after", upd_px, 325);
        check("t2_py_after", upd_py, 238);

        // Negative delta, counter wrap, clamps and colour wrap
        set_cnt(8'hFE, 8'h0E, 8'h10, 8'h10);
        expect_upd("t3_neg", 302, 238, 325, 238, 0, 0);
        ack();
        set_cnt(8'h03, 8'h0E, 8'h10, 8'h10);
        expect_upd("t3_wrap", 307, 238, 302, 238, 0, 0);
        ack();
        set_cnt(8'h82, 8'h8F, 8'h10, 8'h10);
        expect_upd("t3_big", 434, 111, 307, 238, 0, 0);
        ack();
        set_cnt(8'h01, 8'h21, 8'h10, 8'h10);
        expect_upd("t3_big2", 561, 1, 434, 111, 0, 0);
        ack();
        set_cnt(8'h4D, 8'h1D, 8'h05, 8'h20);
        expect_upd("t3_yclamp", 637, 0, 561, 1, 245, 16);
        ack();
        set_cnt(8'h52, 8'h1D, 8'h05, 8'h20);
        expect_upd("t3_xclamp", 639, 0, 637, 0, 245, 16);
        ack();

        // Back-pressure: outputs and address frozen, motion carried into the next frame
        set_cnt(8'h50, 8'h1D, 8'h05, 8'h20);
        expect_upd("t4_hold", 637, 0, 639, 0, 245, 16);
        db_mem[1] = 8'h25;
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CK);
            if (upd_valid !== 1'b1 || upd_x !== 11'd637 || upd_y !== 10'd0 ||
                leta_ad !== 2'd3 || leta_cs_n !== 1'b1) begin
                stable = 1'b0;
            end
        end
        check("t4_stable", stable, 1);
        ack();
        expect_upd("t4_accum", 637, 8, 637, 0, 245, 16);
        ack();

        // Unchanged frame offers nothing; en dropped mid-frame still finishes the frame
        wait_frame(got);
        check("t5_nochange", got, 0);
        n = 0;
        while (!(leta_ad === 2'd2 && leta_cs_n === 1'b0) && n < 200) begin
            @(negedge CK);
            n++;
        end
        check("t5_found_idx2", 32'(n < 200), 1);
        en   = 1'b0;
        saw3 = 1'b0;
        n    = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge CK);
            if (leta_ad === 2'd3 && leta_cs_n === 1'b0) saw3 = 1'b1;
            n++;
        end
        check("t5_idle", busy, 0);
        check("t5_frame_done", saw3, 1);
        repeat (20) @(negedge CK);
        check("t5_stay_idle", busy, 0);
        check("t5_stay_cs_n", leta_cs_n, 1);

        // Asynchronous reset while an update is pending
        en = 1'b1;
        set_cnt(8'h60, 8'h25, 8'h05, 8'h20);
        expect_upd("t6_pre", 639, 8, 637, 8, 245, 16);
        reset_n = 1'b0;
        #1;
        check("t6_valid_drop", upd_valid, 0);
        check("t6_x_init", upd_x, 320);
        check("t6_y_init", upd_y, 240);
        check("t6_px_init", upd_px, 320);
        check("t6_r_init", upd_r, 0);
        check("t6_busy", busy, 0);
        @(negedge CK);
        reset_n = 1'b1;
        wait_frame(got);
        check("t6_prime", got, 0);
        check("t6_prime_x", upd_x, 320);
        set_cnt(8'h61, 8'h25, 8'h05, 8'h20);
        expect_upd("t6_post", 321, 240, 320, 240, 0, 0);
        ack();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
